// File: rtl/ceres_param.sv
// Shared core types: decoded ALU operations and the divide sequencer state
// encoding (also consumed by trace/debug).
package ceres_param;

   typedef enum logic [4:0] {
      OP_ADD,
      OP_SUB,
      OP_SLL,
      OP_SLT,
      OP_SLTU,
      OP_XOR,
      OP_SRL,
      OP_SRA,
      OP_OR,
      OP_AND,
      OP_MUL,
      OP_MULH,
      OP_MULHSU,
      OP_MULHU,
      OP_DIV,
      OP_DIVU,
      OP_REM,
      OP_REMU
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIXUP,
      DONE
   } div_state_e;

   function automatic logic is_div_op(input alu_op_e op);
      return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring divider for the execute stage: DIV/DIVU/REM/REMU
// with RISC-V divide-by-zero and signed-overflow results on a one-cycle fast path.
module div_sequencer
   import ceres_param::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  alu_op_e         alu_ctrl_i,
   input  logic [XLEN-1:0] op_a_i,
   input  logic [XLEN-1:0] op_b_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            valid_o,
   output logic [XLEN-1:0] result_o
);

   localparam int unsigned CNT_W = $clog2(XLEN);

   div_state_e       r_state;
   div_state_e       w_state_nx;
   logic [CNT_W-1:0] r_cnt;
   logic [XLEN-1:0]  r_rem;
   logic [XLEN-1:0]  r_quo;
   logic [XLEN-1:0]  r_absb;
   logic [XLEN-1:0]  r_result;
   logic             r_sign_a;
   logic             r_sign_b;
   alu_op_e          r_op;

   logic             w_accept;
   logic             w_signed;
   logic             w_quo_op;
   logic             w_sign_a;
   logic             w_sign_b;
   logic [XLEN-1:0]  w_abs_a;
   logic [XLEN-1:0]  w_abs_b;
   logic             w_b_zero;
   logic             w_ovf;
   logic             w_fast;
   logic [XLEN-1:0]  w_fast_res;
   logic [XLEN:0]    w_shift;
   logic             w_trial_ok;
   logic [XLEN-1:0]  w_trial;
   logic [XLEN-1:0]  w_quo_fix;
   logic [XLEN-1:0]  w_rem_fix;

   assign w_accept = (r_state == IDLE) && start_i && is_div_op(alu_ctrl_i) && !flush_i;
   assign w_signed = (alu_ctrl_i == OP_DIV) || (alu_ctrl_i == OP_REM);
   assign w_quo_op = (alu_ctrl_i == OP_DIV) || (alu_ctrl_i == OP_DIVU);
   assign w_sign_a = w_signed && op_a_i[XLEN-1];
   assign w_sign_b = w_signed && op_b_i[XLEN-1];
   assign w_abs_a  = w_sign_a ? (~op_a_i + 1'b1) : op_a_i;
   assign w_abs_b  = w_sign_b ? (~op_b_i + 1'b1) : op_b_i;
   assign w_b_zero = (op_b_i == '0);
   assign w_ovf    = w_signed && (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);
   assign w_fast   = w_b_zero || w_ovf;

   // Overflow quotient equals the dividend (most-negative value), remainder is zero.
   always_comb begin
      w_fast_res = '0;
      if (w_b_zero) begin
         w_fast_res = w_quo_op ? '1 : op_a_i;
      end else if (w_quo_op) begin
         w_fast_res = op_a_i;
      end
   end

   // The partial remainder never exceeds |b| after restore, so the subtraction
   // result fits in XLEN bits whenever the trial succeeds.
   assign w_shift    = {r_rem, r_quo[XLEN-1]};
   assign w_trial_ok = (w_shift >= {1'b0, r_absb});
   assign w_trial    = w_shift[XLEN-1:0] - r_absb;

   assign w_quo_fix = ((r_op == OP_DIV) && (r_sign_a ^ r_sign_b)) ? (~r_quo + 1'b1) : r_quo;
   assign w_rem_fix = ((r_op == OP_REM) && r_sign_a) ? (~r_rem + 1'b1) : r_rem;

   always_comb begin
      w_state_nx = r_state;
      if (flush_i) begin
         w_state_nx = IDLE;
      end else begin
         unique case (r_state)
            IDLE:    if (w_accept) w_state_nx = w_fast ? DONE : CALC;
            CALC:    if (r_cnt == CNT_W'(XLEN-1)) w_state_nx = FIXUP;
            FIXUP:   w_state_nx = DONE;
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
         endcase
      end
      busy_o = w_accept || (r_state == CALC) || (r_state == FIXUP);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_absb   <= '0;
         r_result <= '0;
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
         r_op     <= OP_ADD;
      end else begin
         r_state <= w_state_nx;
         unique case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_op     <= alu_ctrl_i;
                  r_sign_a <= w_sign_a;
                  r_sign_b <= w_sign_b;
                  r_absb   <= w_abs_b;
                  r_quo    <= w_abs_a;
                  r_rem    <= '0;
                  r_cnt    <= '0;
                  if (w_fast) r_result <= w_fast_res;
               end
            end
            CALC: begin
               if (!flush_i) begin
                  r_rem <= w_trial_ok ? w_trial : w_shift[XLEN-1:0];
                  r_quo <= {r_quo[XLEN-2:0], w_trial_ok};
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            FIXUP: begin
               if (!flush_i) begin
                  r_result <= ((r_op == OP_DIV) || (r_op == OP_DIVU)) ? w_quo_fix : w_rem_fix;
               end
            end
            default: ;
         endcase
      end
   end

   assign valid_o  = (r_state == DONE) && !flush_i;
   assign result_o = r_result;

endmodule
